// File: rtl/mfp_ahb_interconnect.sv
// AHB-lite interconnect for one master and N_SLV slaves.
// Address decode is combinational against per-slave base/mask windows; the data phase is
// tracked in registers so read data, ready and response can be muxed back from the slave
// that owns the current data phase. Unmapped transfers and slaves that stall past TIMEOUT
// get a two-cycle ERROR response generated here, and each such error is logged.
module mfp_ahb_interconnect #(
  parameter int unsigned           N_SLV    = 4,
  parameter logic [32*N_SLV-1:0]   SLV_BASE = {32'h1f400000, 32'h1f800000,
                                               32'h00000000, 32'h1fc00000},
  parameter logic [32*N_SLV-1:0]   SLV_MASK = {32'h1fc00000, 32'h1fc00000,
                                               32'h10000000, 32'h1fc00000},
  parameter int unsigned           TIMEOUT  = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [N_SLV-1:0]     HSEL_S,
  input  logic [32*N_SLV-1:0]  HRDATA_S,
  input  logic [N_SLV-1:0]     HREADYOUT_S,
  input  logic [N_SLV-1:0]     HRESP_S,
  output logic [15:0]          ERR_COUNT,
  output logic [31:0]          ERR_ADDR,
  output logic                 ERR_TO
);

  // The counter only has to hold 0..TIMEOUT-1 before the timeout fires.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StSlave, StErr1, StErr2} state_e;

  state_e             r_state;
  logic [N_SLV-1:0]   r_sel;
  logic [31:0]        r_addr;
  logic [CntW-1:0]    r_wait;
  logic [15:0]        r_err_count;
  logic [31:0]        r_err_addr;
  logic               r_err_to;

  logic [N_SLV-1:0]   w_hsel;
  logic               w_hit_any;
  logic [31:0]        w_s_rdata;
  logic               w_s_ready;
  logic               w_s_resp;
  logic [15:0]        w_err_count_inc;
  logic               w_timeout;
  logic               w_unused;

  // Write direction and the SEQ/NONSEQ distinction do not affect routing.
  assign w_unused = ^{HWRITE, HTRANS[0]};

  // Priority decode: lowest-index matching window wins, no HTRANS qualification.
  always_comb begin
    w_hsel    = '0;
    w_hit_any = 1'b0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (!w_hit_any && ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        w_hsel[i] = 1'b1;
        w_hit_any = 1'b1;
      end
    end
  end

  assign HSEL_S = w_hsel;

  // AND-OR mux of slave responses using the one-hot data-phase select.
  always_comb begin
    w_s_rdata = '0;
    w_s_ready = 1'b0;
    w_s_resp  = 1'b0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (r_sel[i]) begin
        w_s_rdata = w_s_rdata | HRDATA_S[32*i +: 32];
        w_s_ready = w_s_ready | HREADYOUT_S[i];
        w_s_resp  = w_s_resp  | HRESP_S[i];
      end
    end
  end

  // Master-facing response chosen by the data-phase state.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    unique case (r_state)
      StSlave: begin
        HRDATA = w_s_rdata;
        HREADY = w_s_ready;
        HRESP  = w_s_resp;
      end
      StErr1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      StErr2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
    endcase
  end

  // Saturating increment and timeout condition used by the state machine.
  always_comb begin
    w_err_count_inc = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;
    w_timeout       = (TIMEOUT != 0) && (r_wait == CntW'(TIMEOUT - 1));
  end

  // Data-phase state machine, wait counter and error log.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= StIdle;
      r_sel       <= '0;
      r_addr      <= '0;
      r_wait      <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_err_to    <= 1'b0;
    end else if (HREADY) begin
      // Address phase accepted: load the new data phase.
      r_addr <= HADDR;
      r_wait <= '0;
      if (HTRANS[1] && !w_hit_any) begin
        r_sel       <= '0;
        r_state     <= StErr1;
        r_err_count <= w_err_count_inc;
        r_err_addr  <= HADDR;
        r_err_to    <= 1'b0;
      end else if (HTRANS[1]) begin
        r_sel   <= w_hsel;
        r_state <= StSlave;
      end else begin
        r_sel   <= '0;
        r_state <= StIdle;
      end
    end else begin
      unique case (r_state)
        StErr1: r_state <= StErr2;
        StSlave: begin
          if (w_timeout) begin
            // Abandon the stalled slave; its outputs are ignored from here on.
            r_sel       <= '0;
            r_wait      <= '0;
            r_state     <= StErr1;
            r_err_count <= w_err_count_inc;
            r_err_addr  <= r_addr;
            r_err_to    <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_wait <= r_wait + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ERR_COUNT = r_err_count;
  assign ERR_ADDR  = r_err_addr;
  assign ERR_TO    = r_err_to;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Bench for mfp_ahb_interconnect: acts as the master and as all slaves. A transaction-level
// model predicts, per data-phase cycle, what the master must see (wait, OKAY, two-cycle
// error, timeout) and tracks the expected error log. Unselected and abandoned slaves are
// driven with random junk so that any leakage through the mux shows up.
module tb_mfp_ahb_interconnect;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 4;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic [NS-1:0]   HSEL_S;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]   HREADYOUT_S;
  logic [NS-1:0]   HRESP_S;
  logic [15:0]     ERR_COUNT;
  logic [31:0]     ERR_ADDR;
  logic            ERR_TO;

  mfp_ahb_interconnect #(
    .TIMEOUT (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HSEL_S      (HSEL_S),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .ERR_COUNT   (ERR_COUNT),
    .ERR_ADDR    (ERR_ADDR),
    .ERR_TO      (ERR_TO)
  );

  always #5 HCLK = ~HCLK;

  // One master transfer: slv is the intended slave (-1 = unmapped), waits = slave stall
  // cycles (>= TO means the slave never answers in time).
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          slv;
    int          waits;
    logic [31:0] data;
  } xfer_t;

  xfer_t       q[$];
  xfer_t       cur;
  xfer_t       pend;
  bit          pend_valid;
  int          cur_c;
  logic [15:0] m_cnt;
  logic [31:0] m_addr;
  logic        m_to;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] a, input logic [1:0] t, input int s,
                               input int w, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.trans = t; x.slv = s; x.waits = w; x.data = d;
    return x;
  endfunction

  // Build an address inside a chosen window: bits [28:22] pick the 4 MB region,
  // bit 28 clear lands in the low window; 4 means a deliberately unmapped region.
  function automatic xfer_t gen(input int region, input logic [1:0] t, input int w);
    logic [31:0] a;
    a = $urandom;
    case (region)
      0:       a[28:22] = 7'h7F;
      1:       a[28]    = 1'b0;
      2:       a[28:22] = 7'h7E;
      3:       a[28:22] = 7'h7D;
      default: a[28:22] = 7'($urandom_range(32'h7C, 32'h40));
    endcase
    return mk(a, t, (region < 4) ? region : -1, w, $urandom);
  endfunction

  task automatic log_err(input logic [31:0] a, input logic t);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_addr = a;
    m_to   = t;
  endtask

  // One bus cycle: called just after a rising edge, returns just after the next one.
  task automatic step();
    logic            er, ep, ed_chk, tmo, live;
    logic [31:0]     ed;
    logic [32*NS-1:0] rd;
    logic [NS-1:0]   ro, rs;
    if (!pend_valid) begin
      if (q.size() > 0) pend = q.pop_front();
      else              pend = gen($urandom_range(4, 0), 2'b00, 0);
      pend_valid = 1'b1;
    end
    tmo    = cur.trans[1] && (cur.slv >= 0) && (cur.waits >= int'(TO));
    ed     = '0;
    ed_chk = 1'b0;
    if (!cur.trans[1]) begin
      er = 1'b1; ep = 1'b0; ed_chk = 1'b1;
    end else if (cur.slv < 0) begin
      er = (cur_c == 1); ep = 1'b1;
    end else if (tmo) begin
      er = (cur_c > int'(TO)); ep = (cur_c >= int'(TO));
    end else begin
      er = (cur_c == cur.waits); ep = 1'b0; ed = cur.data; ed_chk = er;
    end
    // During the first error cycle the master may withdraw its queued transfer.
    if (!er && ep && pend.trans[1] && ($urandom_range(1, 0) == 1)) begin
      q.push_front(pend);
      pend = gen($urandom_range(4, 0), 2'b00, 0);
    end
    HADDR  = pend.addr;
    HTRANS = pend.trans;
    HWRITE = 1'($urandom);
    for (int i = 0; i < int'(NS); i++) begin
      rd[32*i +: 32] = $urandom;
      ro[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    live = cur.trans[1] && (cur.slv >= 0) && !(tmo && cur_c >= int'(TO));
    if (live) begin
      rd[32*cur.slv +: 32] = cur.data;
      ro[cur.slv] = (cur_c >= cur.waits);
      rs[cur.slv] = 1'b0;
    end
    HRDATA_S = rd; HREADYOUT_S = ro; HRESP_S = rs;
    #3;
    chk("hsel", HSEL_S, (pend.slv >= 0) ? (32'd1 << pend.slv) : 32'd0);
    chk("hready", HREADY, er);
    chk("hresp", HRESP, ep);
    if (ed_chk) chk("hrdata", HRDATA, ed);
    chk("err_count", ERR_COUNT, m_cnt);
    chk("err_addr", ERR_ADDR, m_addr);
    chk("err_to", ERR_TO, m_to);
    @(posedge HCLK);
    if (tmo && cur_c == int'(TO) - 1) log_err(cur.addr, 1'b1);
    if (er) begin
      if (pend.trans[1] && pend.slv < 0) log_err(pend.addr, 1'b0);
      cur = pend; cur_c = 0; pend_valid = 1'b0;
    end else begin
      cur_c++;
    end
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() > 0 || pend_valid) && g < 4000) begin
      step();
      g++;
    end
    vectors++;
    assert (g < 4000) else begin
      miscompares++;
      $error("FAIL drain_budget observed=%0d expected<4000", g);
    end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic model_reset();
    q.delete();
    cur = mk(32'h0, 2'b00, -1, 0, 32'h0);
    cur_c = 0; pend_valid = 1'b0;
    m_cnt = '0; m_addr = '0; m_to = 1'b0;
  endtask

  initial begin
    int g;
    vectors = 0; miscompares = 0;
    HRESET = 1'b1; HADDR = 32'h1f000000; HTRANS = 2'b00; HWRITE = 1'b0;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;
    model_reset();
    #12;
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_err_count", ERR_COUNT, 16'h0);
    chk("rst_err_addr", ERR_ADDR, 32'h0);
    chk("rst_err_to", ERR_TO, 1'b0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // 0x00001000 falls in the window at bits [63:32] (base 0, mask 0x10000000): slave 1.
    q.push_back(mk(32'h00001000, 2'b10, 1, 0, 32'hCAFE0001));
    q.push_back(mk(32'h1f800004, 2'b10, 2, 0, 32'hCAFE0002));
    q.push_back(mk(32'h1fc00010, 2'b10, 0, 3, 32'h12345678));
    q.push_back(mk(32'h1f000000, 2'b10, -1, 0, 32'h0));
    drain();
    chk("unmapped_count", ERR_COUNT, 16'd1);
    chk("unmapped_addr", ERR_ADDR, 32'h1f000000);
    chk("unmapped_to", ERR_TO, 1'b0);

    q.push_back(mk(32'h1f400000, 2'b10, 3, 1000, 32'h0));
    q.push_back(mk(32'h00000040, 2'b11, 1, 1, 32'hA5A5_0001));
    drain();
    chk("timeout_count", ERR_COUNT, 16'd2);
    chk("timeout_addr", ERR_ADDR, 32'h1f400000);
    chk("timeout_to", ERR_TO, 1'b1);

    q.push_back(mk(32'h1f000000, 2'b00, -1, 0, 32'h0));
    q.push_back(mk(32'h1f000000, 2'b01, -1, 0, 32'h0));
    drain();
    chk("idle_count", ERR_COUNT, 16'd2);

    for (int k = 0; k < 3; k++) q.push_back(gen(4, 2'b10, 0));
    drain();
    chk("b2b_count", ERR_COUNT, 16'd5);

    for (int k = 0; k < 300; k++) begin
      q.push_back(gen($urandom_range(4, 0), 2'($urandom_range(3, 0)),
                      ($urandom_range(7, 0) == 0) ? $urandom_range(6, 4)
                                                  : $urandom_range(3, 0)));
    end
    drain();

    force dut.r_err_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.r_err_count;
    for (int k = 0; k < 3; k++) q.push_back(gen(4, 2'b10, 0));
    drain();
    chk("sat_count", ERR_COUNT, 16'hFFFF);

    // Reset in the middle of an error response.
    q.push_back(gen(4, 2'b10, 0));
    g = 0;
    while (!(cur.trans[1] && cur.slv < 0 && cur_c == 0) && g < 50) begin
      step();
      g++;
    end
    vectors++;
    assert (g < 50) else begin
      miscompares++;
      $error("FAIL reach_err1 observed=%0d expected<50", g);
    end
    HRESET = 1'b1; HTRANS = 2'b00;
    #1;
    chk("mid_rst_hready", HREADY, 1'b1);
    chk("mid_rst_hresp", HRESP, 1'b0);
    chk("mid_rst_hrdata", HRDATA, 32'h0);
    chk("mid_rst_err_count", ERR_COUNT, 16'h0);
    chk("mid_rst_err_addr", ERR_ADDR, 32'h0);
    chk("mid_rst_err_to", ERR_TO, 1'b0);
    model_reset();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int k = 0; k < 40; k++) begin
      q.push_back(gen($urandom_range(4, 0), 2'($urandom_range(3, 0)),
                      $urandom_range(5, 0)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
